// File: rtl/v_issue_ctrl_pkg.sv
// Shared definitions for the vector issue controller: opcode and funct3
// constants, the SEW encoding, the issue-slot state enum and the vl helper.
package rvvLitePkg;

  // Major opcodes recognised by the issue stage
  localparam logic [6:0] OPC_VARITH = 7'h57;
  localparam logic [6:0] OPC_VLOAD  = 7'h07;
  localparam logic [6:0] OPC_VSTORE = 7'h27;

  // funct3 that marks a configuration instruction inside OPC_VARITH
  localparam logic [2:0] F3_VCFG = 3'd7;

  // Element width encoding carried on req_sew and the sew output
  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  // One-entry issue slot
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } issue_state_e;

  // Number of elements that fit in one vector register at the given SEW
  function automatic logic [63:0] vlmax_calc(input int unsigned vlen,
                                             input logic [1:0] sew_code);
    return 64'(vlen) >> (32'd3 + 32'(sew_code));
  endfunction

  // New vl for a configuration instruction: either the full register
  // (rs1=x0, rd!=x0 form) or the requested length clipped to vlmax
  function automatic logic [63:0] vl_calc(input logic [63:0] avl,
                                          input logic        avl_max,
                                          input logic [1:0]  sew_code,
                                          input int unsigned vlen);
    logic [63:0] vlmax;
    vlmax = vlmax_calc(vlen, sew_code);
    if (avl_max) begin
      return vlmax;
    end
    return (avl < vlmax) ? avl : vlmax;
  endfunction

endpackage

// File: rtl/v_issue_ctrl.sv
// Vector issue controller: holds one decoded instruction in a single-entry
// slot, releases it to the execution units when they are free and a
// response credit is available, and maintains the architectural vl/sew.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | no instruction held; a new request is always accepted
// ST_HELD  | a legal vector instruction is presented on instr_valid/is_*
//
// Illegal opcodes are accepted and dropped without ever occupying the slot;
// they only raise a one-cycle illegal pulse.
module v_issue_ctrl
  import rvvLitePkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int VL_BITS         = 11,
  parameter int VLEN            = 1024,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [6:0]            req_opcode,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_avl,
  input  logic                  req_avl_max,
  input  logic [1:0]            req_sew,

  output logic                  instr_valid,
  output logic                  is_vcfg,
  output logic                  is_valu,
  output logic                  is_vload,
  output logic                  is_vstore,
  output logic                  stall,

  input  logic                  exec_busy,
  input  logic                  resp_valid,

  output logic [VL_BITS-1:0]    vl,
  output logic [1:0]            sew,
  output logic                  illegal,
  output logic                  idle
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CREDITS_FULL = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CREDIT_ONE   = CW'(1);

  issue_state_e          state;
  logic [CW-1:0]         credits;

  logic [DATA_WIDTH-1:0] slot_avl;
  logic                  slot_avl_max;
  logic [1:0]            slot_sew;

  logic                  dec_vcfg;
  logic                  dec_valu;
  logic                  dec_vload;
  logic                  dec_vstore;
  logic                  dec_legal;

  logic                  credits_zero;
  logic                  fire;
  logic                  accept;
  logic [VL_BITS-1:0]    vl_next;

  // Decode of the incoming request; exactly one class is set for legal ones
  always_comb begin
    dec_vcfg   = (req_opcode == OPC_VARITH) && (req_funct3 == F3_VCFG);
    dec_valu   = (req_opcode == OPC_VARITH) && (req_funct3 != F3_VCFG);
    dec_vload  = (req_opcode == OPC_VLOAD);
    dec_vstore = (req_opcode == OPC_VSTORE);
    dec_legal  = dec_vcfg | dec_valu | dec_vload | dec_vstore;
  end

  // Handshake and release conditions; a fire frees the slot in the same
  // cycle so a new request can be taken back-to-back
  always_comb begin
    credits_zero = (credits == '0);
    instr_valid  = (state == ST_HELD);
    stall        = instr_valid & (exec_busy | credits_zero);
    fire         = instr_valid & ~stall;
    req_ready    = (state == ST_EMPTY) | fire;
    accept       = req_valid & req_ready;
    idle         = (state == ST_EMPTY) & (credits == CREDITS_FULL);
  end

  // Configuration result computed from the held slot, applied only on fire
  always_comb begin
    vl_next = VL_BITS'(vl_calc(64'(slot_avl), slot_avl_max, slot_sew, VLEN));
  end

  // Issue-slot FSM with registered class flags and illegal pulse; the slot
  // only changes on accept, which cannot happen while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_EMPTY;
      is_vcfg      <= 1'b0;
      is_valu      <= 1'b0;
      is_vload     <= 1'b0;
      is_vstore    <= 1'b0;
      illegal      <= 1'b0;
      slot_avl     <= '0;
      slot_avl_max <= 1'b0;
      slot_sew     <= '0;
    end else begin
      illegal <= accept & ~dec_legal;
      if (accept && dec_legal) begin
        state        <= ST_HELD;
        is_vcfg      <= dec_vcfg;
        is_valu      <= dec_valu;
        is_vload     <= dec_vload;
        is_vstore    <= dec_vstore;
        slot_avl     <= req_avl;
        slot_avl_max <= req_avl_max;
        slot_sew     <= req_sew;
      end else if (fire) begin
        state     <= ST_EMPTY;
        is_vcfg   <= 1'b0;
        is_valu   <= 1'b0;
        is_vload  <= 1'b0;
        is_vstore <= 1'b0;
      end
    end
  end

  // Response credits: one consumed per fire, one returned per response;
  // a response arriving at full credits is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CREDITS_FULL;
    end else if (fire && !resp_valid) begin
      credits <= credits - CREDIT_ONE;
    end else if (resp_valid && !fire && (credits != CREDITS_FULL)) begin
      credits <= credits + CREDIT_ONE;
    end
  end

  // Architectural vl/sew, updated only when a configuration instruction fires
  always_ff @(posedge clk) begin
    if (rst) begin
      vl  <= '0;
      sew <= '0;
    end else if (fire && is_vcfg) begin
      vl  <= vl_next;
      sew <= slot_sew;
    end
  end

endmodule
